uart_tx_resultado: RTL and testbench

UART_TX_RESULTADO -- requirements
Module: uart_tx_resultado

---
 rtl/uart_tx_resultado.sv | 158 +++++++++++++++
 tb/tb_uart_tx_resultado.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_resultado.sv
// Serialises a signed 26-bit result as four 8N1 UART bytes, LSB byte first, sign-extended to 32 bits.
// Define TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_resultado #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic               Clk_G,
  input  logic               Rst_G,
  input  logic               Tx_En,
  input  logic signed [25:0] Dato,
  output logic               Tx,
  output logic               Tx_Busy,
  output logic               Tx_Done
);

  localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] shreg_q, shreg_d;
  logic        tx_q, busy_q, done_q;
  logic        tx_c, baud_end;
`ifdef TX_PARITY_EN
  logic        par_q, par_d;
`endif

  always_ff @(posedge Clk_G or negedge Rst_G) begin
    if (!Rst_G) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_c;
      busy_q  <= (state_q != StIdle);
      // Outputs lag the state by one cycle, so the frame ends one cycle after the FSM idles.
      done_q  <= busy_q && (state_q == StIdle);
`ifdef TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shreg_d  = shreg_q;
    tx_c     = 1'b1;
    baud_end = (baud_q == BaudLast);
`ifdef TX_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        // busy_q still covers the last stop-bit cycle while the FSM already idles.
        if (Tx_En && !busy_q) begin
          state_d = StStart;
          shreg_d = {{6{Dato[25]}}, Dato};
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      StStart: begin
        tx_c = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
`ifdef TX_PARITY_EN
          par_d   = 1'b0;
`endif
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StData: begin
        tx_c = shreg_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[31:1]};
`ifdef TX_PARITY_EN
          par_d   = par_q ^ shreg_q[0];
`endif
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef TX_PARITY_EN
      StParity: begin
        tx_c = par_q;
        if (baud_end) begin
          baud_d  = '0;
          state_d = StStop;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      StStop: begin
        tx_c = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (byte_q == 2'd3) begin
            byte_d  = '0;
            state_d = StIdle;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = StStart;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign Tx      = tx_q;
  assign Tx_Busy = busy_q;
  assign Tx_Done = done_q;

endmodule

// File: tb/tb_uart_tx_resultado.sv
// Randomised bench for uart_tx_resultado: compares the serial line cycle by cycle against a
// frame model built from the byte/bit arithmetic of the UART format.
module tb_uart_tx_resultado;

  localparam int unsigned Cpb = 4;
`ifdef TX_PARITY_EN
  localparam int unsigned BitsPerByte = 11;
`else
  localparam int unsigned BitsPerByte = 10;
`endif
  localparam int unsigned FrameLen = 4 * BitsPerByte * Cpb;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               tx_en = 1'b0;
  logic signed [25:0] dato = '0;
  logic               tx, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_resultado #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .Clk_G  (clk),
    .Rst_G  (rst_n),
    .Tx_En  (tx_en),
    .Dato   (dato),
    .Tx     (tx),
    .Tx_Busy(busy),
    .Tx_Done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic signed [25:0] d);
    int v;
    v = d;
    return v;
  endfunction

  // Expected line level k cycles after the first start bit begins.
  function automatic logic exp_level(input logic [31:0] w, input int k);
    int idx, b, pos;
    logic [7:0] byte_v;
    idx    = k / Cpb;
    b      = idx / BitsPerByte;
    pos    = idx % BitsPerByte;
    byte_v = w[8*b +: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return byte_v[pos-1];
    if (pos == 9 && BitsPerByte == 11) return ^byte_v;
    return 1'b1;
  endfunction

  // Called one negedge after Tx_En was raised: the accepting edge has just passed.
  task automatic accept_check();
    @(negedge clk);
    tx_en = 1'b0;
    check_eq("latency_tx_high", 32'(tx), 32'd1);
    check_eq("latency_busy_low", 32'(busy), 32'd0);
    check_eq("latency_done_low", 32'(done), 32'd0);
  endtask

  task automatic start_tx(input logic signed [25:0] d);
    dato  = d;
    tx_en = 1'b1;
    accept_check();
  endtask

  task automatic watch_frame(input logic [31:0] w, input int inject_k, input logic chain,
                             input logic signed [25:0] next_d);
    logic tx_s[FrameLen];
    int wave_err, busy_err, done_err, s;
    logic [7:0] dec;
    wave_err = 0;
    busy_err = 0;
    done_err = 0;
    for (int k = 0; k < FrameLen; k++) begin
      @(negedge clk);
      tx_s[k] = tx;
      if (tx !== exp_level(w, k)) wave_err++;
      if (busy !== 1'b1) busy_err++;
      if (done !== 1'b0) done_err++;
      if (k == inject_k) begin
        tx_en = 1'b1;
        dato  = 26'($urandom);
      end else begin
        tx_en = 1'b0;
      end
    end
    check_eq("wave_mismatch_cycles", wave_err, 0);
    check_eq("busy_low_in_frame", busy_err, 0);
    check_eq("done_early", done_err, 0);
    for (int b = 0; b < 4; b++) begin
      s   = b * BitsPerByte * Cpb + Cpb / 2;
      dec = '0;
      check_eq("start_bit", 32'(tx_s[s]), 32'd0);
      for (int i = 0; i < 8; i++) dec[i] = tx_s[s + (i + 1) * Cpb];
      check_eq("byte", 32'(dec), 32'(w[8*b +: 8]));
`ifdef TX_PARITY_EN
      check_eq("parity_bit", 32'(tx_s[s + 9 * Cpb]), 32'(^w[8*b +: 8]));
`endif
      check_eq("stop_bit", 32'(tx_s[s + (BitsPerByte - 1) * Cpb]), 32'd1);
    end
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("busy_fall_with_done", 32'(busy), 32'd0);
    check_eq("tx_idle_at_done", 32'(tx), 32'd1);
    if (chain) begin
      dato  = next_d;
      tx_en = 1'b1;
    end else begin
      tx_en = 1'b0;
      @(negedge clk);
      check_eq("done_single_cycle", 32'(done), 32'd0);
    end
  endtask

  task automatic idle_watch(input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check_eq("idle_quiet", bad, 0);
  endtask

  initial begin
    logic signed [25:0] cur_d, next_d;
    logic chained, chain;
    int inj;

    repeat (3) @(negedge clk);
    check_eq("reset_tx", 32'(tx), 32'd1);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start_tx(26'sh0000001);
    watch_frame(sext(26'sh0000001), -1, 1'b0, '0);
    start_tx(-26'sd1);
    watch_frame(sext(-26'sd1), -1, 1'b0, '0);
    start_tx(26'sh2000000);
    watch_frame(32'hFE00_0000, -1, 1'b0, '0);

    // Mid-frame request must not disturb the frame or queue a second one.
    start_tx(26'sh0000001);
    watch_frame(sext(26'sh0000001), 20, 1'b0, '0);
    idle_watch(3 * BitsPerByte * Cpb);

    // Request in the Tx_Done cycle starts the next frame immediately.
    start_tx(26'sh1234567);
    watch_frame(sext(26'sh1234567), -1, 1'b1, 26'sh0ABCDEF);
    accept_check();
    watch_frame(sext(26'sh0ABCDEF), -1, 1'b0, '0);

    // Reset during the start bit of byte 2 aborts the frame at once.
    start_tx(26'($urandom));
    for (int k = 0; k <= 2 * BitsPerByte * Cpb + 1; k++) @(negedge clk);
    check_eq("pre_reset_start_bit", 32'(tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset_tx", 32'(tx), 32'd1);
    check_eq("async_reset_busy", 32'(busy), 32'd0);
    check_eq("async_reset_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_watch(2 * BitsPerByte * Cpb);
    start_tx(26'sh0000055);
    watch_frame(32'h0000_0055, -1, 1'b0, '0);

    chained = 1'b0;
    cur_d   = 26'($urandom);
    for (int i = 0; i < 10; i++) begin
      next_d = 26'($urandom);
      chain  = (i < 9) && ($urandom_range(0, 1) == 1);
      inj    = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, FrameLen - 1));
      if (chained) accept_check();
      else start_tx(cur_d);
      watch_frame(sext(cur_d), inj, chain, next_d);
      cur_d   = next_d;
      chained = chain;
      if (!chain) idle_watch(int'($urandom_range(1, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
